// File: rtl/div_iter.sv
// Iterative radix-2 restoring unsigned divider with a req/ready handshake; one quotient bit per cycle.
// Optional DIV_REUSE_EN: a repeat of the last completed {a, b} pair returns the held result in one cycle.
module div_iter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    input  logic                    is_q_i,
    output logic [2*DATA_WIDTH:0]   result_o,
    output logic                    ready_o
);
    localparam int unsigned W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [W:0]           rem, rem_step, trial;
    logic [W-1:0]         quo, quo_step, dvs;
    logic                 is_q;
    logic                 last_iter;
    logic                 hit;
    logic                 unused_bits;

    // is_q is informational only and rem[W] is always 0 after a restoring step
    assign unused_bits = ^{is_q, rem[W]};

    always_comb begin
        trial     = {rem[W-1:0], quo[W-1]} - {1'b0, dvs};
        last_iter = (cnt == CNT_WIDTH'(W - 1));
        if (!trial[W]) begin
            rem_step = trial;
            quo_step = {quo[W-2:0], 1'b1};
        end else begin
            rem_step = {rem[W-1:0], quo[W-1]};
            quo_step = {quo[W-2:0], 1'b0};
        end
    end

`ifdef DIV_REUSE_EN
    logic [W-1:0] dvd, last_a, last_b;
    logic         last_valid;

    always_comb hit = last_valid && (a_i == last_a) && (b_i == last_b);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dvd        <= '0;
            last_a     <= '0;
            last_b     <= '0;
            last_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_i && !hit) begin
                    dvd <= a_i;
                    if (b_i == '0) begin
                        last_a     <= a_i;
                        last_b     <= b_i;
                        last_valid <= 1'b1;
                    end
                end
                BUSY: if (!req_i) begin
                    last_valid <= 1'b0;
                end else if (last_iter) begin
                    last_a     <= dvd;
                    last_b     <= dvs;
                    last_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
`else
    always_comb hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        case (state)
            IDLE: if (req_i) state_nxt = (hit || b_i == '0) ? DONE : BUSY;
            BUSY: begin
                if (!req_i)         state_nxt = IDLE;
                else if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                ready_o   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            is_q     <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: if (req_i && !hit) begin
                    dvs  <= b_i;
                    is_q <= is_q_i;
                    cnt  <= '0;
                    if (b_i == '0) begin
                        quo      <= '1;
                        rem      <= {1'b0, a_i};
                        result_o <= {a_i, 1'b0, {W{1'b1}}};
                    end else begin
                        rem <= '0;
                        quo <= a_i;
                    end
                end
                BUSY: if (req_i) begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (last_iter) result_o <= {rem_step[W-1:0], 1'b0, quo_step};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: expected results are queued at issue and checked on each ready_o pulse.
module tb_div_iter;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst, req, is_q;
    logic [W-1:0]   a, b;
    logic [2*W:0]   result;
    logic           ready;

    int total = 0;
    int bad   = 0;
    logic [2*W:0] exp_q[$];

    always #5 clk = ~clk;

    div_iter #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .a_i(a), .b_i(b),
        .is_q_i(is_q), .result_o(result), .ready_o(ready)
    );

    function automatic logic [2*W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        if (y == 0) return {x, 1'b0, {W{1'b1}}};
        return {x % y, 1'b0, x / y};
    endfunction

    // called at a negedge; the following posedge is the start edge
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic q);
        a = x; b = y; is_q = q; req = 1'b1;
        exp_q.push_back(model(x, y));
    endtask

    task automatic wait_ready(output int lat, output bit got);
        lat = 0; got = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = i; got = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [2*W:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; a = '0; b = '0; is_q = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got=%b want=0", ready); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got=%h want=0", result); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat; bit got; logic [2*W:0] e, held;
        issue(100, 7, 1'b1);
        wait_ready(lat, got);
        total++; if (!got || lat != 33) begin bad++; $display("FAIL basic_latency: got=%0d seen=%0b want=33", lat, got); end
        e = pop_exp();
        total++; if (result !== e) begin bad++; $display("FAIL basic_result: got=%h want=%h", result, e); end
        total++; if (result[W] !== 1'b0 || result[W-1:0] !== 32'd14 || result[2*W:W+1] !== 32'd2) begin
            bad++; $display("FAIL basic_fields: got=%h want q=14 r=2 bit32=0", result);
        end
        held = result;
        req = 1'b0;
        @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL basic_pulse_width: got=%b want=0", ready); end
        total++; if (result !== held) begin bad++; $display("FAIL basic_hold: got=%h want=%h", result, held); end
    endtask

    task automatic test_div_zero;
        int lat; bit got; logic [2*W:0] e;
        issue(32'hFFFF_FFFF, 1, 1'b1);
        wait_ready(lat, got);
        total++; if (!got || lat != 33) begin bad++; $display("FAIL max_by_one_latency: got=%0d seen=%0b want=33", lat, got); end
        e = pop_exp();
        total++; if (result !== e) begin bad++; $display("FAIL max_by_one_result: got=%h want=%h", result, e); end
        req = 1'b0;
        @(negedge clk);
        issue(5, 0, 1'b1);
        wait_ready(lat, got);
        total++; if (!got || lat != 1) begin bad++; $display("FAIL div_zero_latency: got=%0d seen=%0b want=1", lat, got); end
        e = pop_exp();
        total++; if (result !== e) begin bad++; $display("FAIL div_zero_result: got=%h want=%h", result, e); end
        req = 1'b0;
        @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL div_zero_pulse_width: got=%b want=0", ready); end
    endtask

    task automatic test_back_to_back;
        int lat; bit got; logic [2*W:0] e;
        issue(32'h8000_0000, 32'h8000_0001, 1'b1);
        wait_ready(lat, got);
        total++; if (!got || lat != 33) begin bad++; $display("FAIL b2b_first_latency: got=%0d seen=%0b want=33", lat, got); end
        e = pop_exp();
        total++; if (result !== e) begin bad++; $display("FAIL b2b_first_result: got=%h want=%h", result, e); end
        // req stays high: DONE edge must not start, the following IDLE edge does
        issue(9, 3, 1'b1);
        wait_ready(lat, got);
        total++; if (!got || lat != 34) begin bad++; $display("FAIL b2b_second_latency: got=%0d seen=%0b want=34", lat, got); end
        e = pop_exp();
        total++; if (result !== e) begin bad++; $display("FAIL b2b_second_result: got=%h want=%h", result, e); end
        req = 1'b0;
        @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_pulse_width: got=%b want=0", ready); end
    endtask

    task automatic test_abort;
        int lat; bit got, seen; logic [2*W:0] e, held;
        held = result;
        a = 1000; b = 3; is_q = 1'b1; req = 1'b1;
        repeat (11) @(negedge clk);
        req = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready === 1'b1) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL abort_no_ready: got=1 want=0"); end
        total++; if (result !== held) begin bad++; $display("FAIL abort_hold: got=%h want=%h", result, held); end
        issue(10, 4, 1'b1);
        wait_ready(lat, got);
        total++; if (!got || lat != 33) begin bad++; $display("FAIL after_abort_latency: got=%0d seen=%0b want=33", lat, got); end
        e = pop_exp();
        total++; if (result !== e) begin bad++; $display("FAIL after_abort_result: got=%h want=%h", result, e); end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat; bit got; logic [2*W:0] e;
        a = 50; b = 5; is_q = 1'b1; req = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1; req = 1'b0;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL midreset_ready: got=%b want=0", ready); end
        total++; if (result !== '0) begin bad++; $display("FAIL midreset_result: got=%h want=0", result); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(50, 5, 1'b1);
        wait_ready(lat, got);
        total++; if (!got || lat != 33) begin bad++; $display("FAIL after_reset_latency: got=%0d seen=%0b want=33", lat, got); end
        e = pop_exp();
        total++; if (result !== e) begin bad++; $display("FAIL after_reset_result: got=%h want=%h", result, e); end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reuse;
        int lat, want; bit got; logic [2*W:0] e;
`ifdef DIV_REUSE_EN
        want = 1;
`else
        want = 33;
`endif
        issue(1234, 10, 1'b1);
        wait_ready(lat, got);
        total++; if (!got || lat != 33) begin bad++; $display("FAIL reuse_first_latency: got=%0d seen=%0b want=33", lat, got); end
        e = pop_exp();
        total++; if (result !== e) begin bad++; $display("FAIL reuse_first_result: got=%h want=%h", result, e); end
        req = 1'b0;
        @(negedge clk);
        issue(1234, 10, 1'b0);
        wait_ready(lat, got);
        total++; if (!got || lat != want) begin bad++; $display("FAIL reuse_second_latency: got=%0d seen=%0b want=%0d", lat, got, want); end
        e = pop_exp();
        total++; if (result !== e) begin bad++; $display("FAIL reuse_second_result: got=%h want=%h", result, e); end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        int lat, want; bit got; logic [W-1:0] x, y; logic [2*W:0] e;
        for (int i = 0; i < 8; i++) begin
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            if (i == 0) y = x;
            if (i == 1) begin x = 3; y = 7; end
            if (i == 2) begin x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; end
            want = (y == 0) ? 1 : 33;
            issue(x, y, i[0]);
            wait_ready(lat, got);
            total++; if (!got || lat != want) begin bad++; $display("FAIL random_latency[%0d]: got=%0d seen=%0b want=%0d", i, lat, got, want); end
            e = pop_exp();
            total++; if (result !== e) begin bad++; $display("FAIL random_result[%0d]: a=%h b=%h got=%h want=%h", i, x, y, result, e); end
            req = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        test_reuse;
        test_random;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 restoring unsigned divider. It is the responder side of the req/ready divide handshake driven by the EX-stage R/M-type execute unit.
- The initiator holds req_i and operands stable, and stalls the pipeline while req_i is high and ready_o is low.
- Sign pre- and post-correction for DIV/REM stays in the initiator. This block sees only unsigned magnitudes.
- Quotient and remainder are always produced together in one packed result.

Parameters:
DATA_WIDTH, 32, operand/quotient/remainder width W
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > W

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
req_i  input  1  divide request; held high by the initiator until ready_o is seen
a_i  input  W  dividend (unsigned)
b_i  input  W  divisor (unsigned)
is_q_i  input  1  1 = DIV/DIVU, 0 = REM/REMU; latched, informational only
result_o  output  2W+1  [2W:W+1] remainder, [W] always 0, [W-1:0] quotient
ready_o  output  1  one-cycle pulse, result_o valid

Behaviour:
- Clock/reset: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset values: state=IDLE, counter=0, ready_o=0, result_o=0, internal dividend/divisor/remainder registers=0, latched is_q=0.
- States:
  - IDLE: on an edge with req_i=1, latch a_i, b_i, is_q_i.
    - If b_i==0, go to DONE. Load quotient=all ones and remainder=a_i.
    - Otherwise go to BUSY with counter=0, rem=0 (W+1 bits), quo=a_i.
  - BUSY: each edge performs one iteration.
    - Compute t = {rem[W-1:0], quo[W-1]} - {1'b0, b}.
    - If t[W]==0: rem=t, quo={quo[W-2:0],1}. Otherwise: rem={rem[W-1:0],quo[W-1]}, quo={quo[W-2:0],0}.
    - counter increments each iteration. After iteration W-1, go to DONE and load result_o.
  - DONE: ready_o=1 for exactly this one cycle; unconditionally go to IDLE on the next edge.
- Latency, counted from the IDLE edge that samples req_i=1:
  - Normal: ready_o high in the cycle after edge W+1, i.e. 33 cycles for W=32.
  - Divide-by-zero: ready_o high in the cycle after that edge (1 cycle).
- Back-to-back: req_i may stay high through DONE (next instruction is also M-type divide). The IDLE cycle after DONE samples it and starts a new operation. The DONE cycle itself never starts an operation.
- Abort: if req_i is 0 on any edge in BUSY, the operation is abandoned. Go to IDLE; no ready_o pulse; result_o keeps its previous value. This covers pipeline flush.
- Operand changes during BUSY are ignored; only the values latched at start are used.
- result_o holds its value from DONE until the next DONE. It is never cleared by IDLE.
- Reset asserted mid-operation returns immediately to the reset values. No ready_o is produced for the aborted operation.
- Remainder is W bits: rem[W] is always 0 after a restoring step; only rem[W-1:0] is output.

Optional Feature:
- Macro: DIV_REUSE_EN.
- Defined:
  - Keep the last completed {a, b} pair and a valid flag. The flag is cleared by reset and by abort.
  - An IDLE request whose a_i and b_i match a valid pair goes directly to DONE with result_o unchanged (1-cycle latency). is_q_i is not part of the match, so a DIV followed by REM on the same operands hits.
  - Divide-by-zero results are also recorded.
- Undefined: no compare logic or storage; every request runs the full sequence.

Test Plan:
1. a=100, b=7, req held -> ready_o pulse 33 cycles after the start edge; result_o quotient=14, remainder=2, bit[32]=0.
2. a=0xFFFFFFFF, b=1, then a=5, b=0 -> first: q=0xFFFFFFFF, r=0 after 33 cycles; second: q=0xFFFFFFFF, r=5, ready_o 1 cycle after start.
3. a=0x80000000, b=0x80000001; req held through DONE with new operands a=9, b=3 -> q=0, r=0x80000000; then the second op starts in the IDLE cycle after DONE, q=3, r=0. ready_o pulses are each exactly one cycle.
4. Start a=1000, b=3; drop req_i at iteration 10 -> no ready_o, result_o unchanged, state IDLE. Next req a=10, b=4 -> q=2, r=2 after 33 cycles.
5. Start a=50, b=5; assert rst_i asynchronously mid-BUSY -> ready_o=0 and result_o=0 immediately. After release, a=50, b=5 -> q=10, r=0.
6. With DIV_REUSE_EN: a=1234, b=10 (is_q=1) completes in 33 cycles; then the same operands with is_q=0 -> ready_o 1 cycle after start, r=4, q=123. Without the macro the second request takes 33 cycles.
